// File: rtl/ntt_stage_ctrl_if.sv
// Interface between the NTT stage controller and its neighbours.
//   master : top-level sequencer side (drives start/span_log, observes the rest)
//   slave  : ntt_stage_ctrl side
// Signals:
//   start, span_log            stage request and log2 half-span
//   busy, done, err            stage status pulses/levels
//   rd_en, rd_addr_u/v, tw_idx coefficient RAM read pair and twiddle index
//   wr_en, wr_addr_u/v         write-back pair aligned with stage_bf outputs
interface ntt_stage_ctrl_if #(
    parameter int unsigned LOG_N = 8
);
    logic                    start;
    logic [$clog2(LOG_N):0]  span_log;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    rd_en;
    logic [LOG_N-1:0]        rd_addr_u;
    logic [LOG_N-1:0]        rd_addr_v;
    logic [LOG_N-2:0]        tw_idx;
    logic                    wr_en;
    logic [LOG_N-1:0]        wr_addr_u;
    logic [LOG_N-1:0]        wr_addr_v;

    modport master (
        output start, span_log,
        input  busy, done, err, rd_en, rd_addr_u, rd_addr_v, tw_idx,
        input  wr_en, wr_addr_u, wr_addr_v
    );

    modport slave (
        input  start, span_log,
        output busy, done, err, rd_en, rd_addr_u, rd_addr_v, tw_idx,
        output wr_en, wr_addr_u, wr_addr_v
    );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// Sequences one radix-2 NTT stage through the stage_bf butterfly pipeline.
// Issues one (u,v) coefficient read pair per cycle plus its twiddle index, then delays
// each pair by the RAM read + butterfly latency to produce aligned write-back strobes.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : ntt_stage_ctrl_if slave modport (start/span_log in; status, read and write out)
module ntt_stage_ctrl #(
    parameter int unsigned LOG_N  = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 12
) (
    input  logic              clk,
    input  logic              rst,
    ntt_stage_ctrl_if.slave   bus
);
    localparam int unsigned PIPE_LAT = RD_LAT + BF_LAT;
    localparam int unsigned SLW      = $clog2(LOG_N) + 1;
    localparam int unsigned DW       = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e           state_q;
    logic [LOG_N-2:0] k_q;
    logic [SLW-1:0]   s_q;
    logic [DW-1:0]    drain_q;
    logic             busy_q, done_q, err_q, rd_en_q;
    logic [LOG_N-1:0] rd_u_q, rd_v_q;
    logic [LOG_N-2:0] tw_q;

    logic [PIPE_LAT-1:0] sr_en_q;
    logic [LOG_N-1:0]    sr_u_q [PIPE_LAT];
    logic [LOG_N-1:0]    sr_v_q [PIPE_LAT];

    // Address generation for pair k under latched half-span s.
    logic [LOG_N-1:0] kk, mask, grp, off, addr_u, addr_v;

    always_comb begin
        kk     = LOG_N'(k_q);
        mask   = (LOG_N'(1) << s_q) - LOG_N'(1);
        grp    = kk >> s_q;
        off    = kk & mask;
        addr_u = (grp << (s_q + 1'b1)) | off;
        // bit s of addr_u is always clear, so OR equals +span
        addr_v = addr_u | (LOG_N'(1) << s_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            s_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
            rd_u_q  <= '0;
            rd_v_q  <= '0;
            tw_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.span_log < SLW'(LOG_N)) begin
                            state_q <= StIssue;
                            s_q     <= bus.span_log;
                            k_q     <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    rd_en_q <= 1'b1;
                    rd_u_q  <= addr_u;
                    rd_v_q  <= addr_v;
                    tw_q    <= grp[LOG_N-2:0];
                    if (k_q == '1) begin
                        state_q <= StDrain;
                        drain_q <= '0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StDrain: begin
                    // last pair leaves the delay line PIPE_LAT cycles after the last read
                    if (drain_q == DW'(PIPE_LAT)) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_en_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                sr_u_q[i] <= '0;
                sr_v_q[i] <= '0;
            end
        end else begin
            sr_en_q   <= {sr_en_q[PIPE_LAT-2:0], rd_en_q};
            sr_u_q[0] <= rd_u_q;
            sr_v_q[0] <= rd_v_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sr_u_q[i] <= sr_u_q[i-1];
                sr_v_q[i] <= sr_v_q[i-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_u = rd_u_q;
    assign bus.rd_addr_v = rd_v_q;
    assign bus.tw_idx    = tw_q;
    assign bus.wr_en     = sr_en_q[PIPE_LAT-1];
    assign bus.wr_addr_u = sr_u_q[PIPE_LAT-1];
    assign bus.wr_addr_v = sr_v_q[PIPE_LAT-1];
endmodule
